// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: owns the fetch PC, issues in-order imem
// requests, buffers returned words with their PCs and presents them to DE.
module otter_fetch_unit #(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [1:0]  pc_source,
    input  logic [31:0] jalr_target,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        de_valid,
    output logic [31:0] de_pc,
    output logic [31:0] de_pc4,
    output logic [31:0] de_ir
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] ocnt;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] fcnt;
    logic [PW-1:0] pq_wr;
    logic [PW-1:0] pq_rd;
    logic [PW-1:0] f_wr;
    logic [PW-1:0] f_rd;

    logic [31:0] pq_mem [FIFO_DEPTH];
    logic [31:0] f_pc   [FIFO_DEPTH];
    logic [31:0] f_ir   [FIFO_DEPTH];

    logic          redirect;
    logic [31:0]   target;
    logic [CW-1:0] credit;
    logic          issue;
    logic          drop;
    logic          push;
    logic          pop;

    always_comb begin
        target = 32'h0;
        case (pc_source)
            2'd1:    target = jalr_target;
            2'd2:    target = branch_target;
            2'd3:    target = jal_target;
            default: target = 32'h0;
        endcase
    end

    assign redirect = (pc_source != 2'd0);

    // Credit counts live (non-dropped) requests plus buffered words,
    // so every accepted response is guaranteed a FIFO slot.
    assign credit = (ocnt - dcnt) + fcnt;

    assign imem_req  = RST_N && !redirect
                       && (ocnt < MAXO_C)
                       && (credit < DEPTH_C);
    assign imem_addr = fetch_pc;

    assign issue = imem_req && imem_gnt;
    assign drop  = imem_rvalid && (redirect || (dcnt != '0));
    assign push  = imem_rvalid && !drop;

    assign de_valid = (fcnt != '0);
    assign pop      = de_valid && !STALL;

    assign de_pc  = de_valid ? f_pc[f_rd] : 32'h0;
    assign de_ir  = de_valid ? f_ir[f_rd] : 32'h0;
    assign de_pc4 = de_valid ? (f_pc[f_rd] + 32'd4) : 32'h0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_pc <= RESET_VEC;
            ocnt     <= '0;
            dcnt     <= '0;
            fcnt     <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
            f_wr     <= '0;
            f_rd     <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= {target[31:2], 2'b00};
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (issue) begin
                pq_wr <= pq_wr + PTR_ONE;
            end
            if (imem_rvalid) begin
                pq_rd <= pq_rd + PTR_ONE;
            end

            ocnt <= ocnt + CW'(issue) - CW'(imem_rvalid);

            // Everything still in flight after a redirect belongs to the
            // abandoned path.
            if (redirect) begin
                dcnt <= ocnt - CW'(imem_rvalid);
            end else if (imem_rvalid && (dcnt != '0)) begin
                dcnt <= dcnt - CNT_ONE;
            end

            if (redirect) begin
                fcnt <= '0;
                f_wr <= '0;
                f_rd <= '0;
            end else begin
                if (push) begin
                    f_wr <= f_wr + PTR_ONE;
                end
                if (pop) begin
                    f_rd <= f_rd + PTR_ONE;
                end
                fcnt <= fcnt + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: validity is tracked by the counters.
    always_ff @(posedge CLK) begin
        if (issue) begin
            pq_mem[pq_wr] <= fetch_pc;
        end
        if (push) begin
            f_pc[f_wr] <= pq_mem[pq_rd];
            f_ir[f_wr] <= imem_rdata;
        end
    end

    a_rvalid_outst: assert property (
        @(posedge CLK) disable iff (!RST_N)
        imem_rvalid |-> (ocnt != '0));

    a_flush_match: assert property (
        @(posedge CLK) disable iff (!RST_N)
        FLUSH == redirect);

endmodule
